// File: rtl/cv32e40s_rf_scrub_ctrl_if.sv
// Register-file write/scrub bus between the WB stage, the scrub controller
// and the register file wrapper. The controller connects through the slave
// modport; the environment (pipeline + RF wrapper) connects through master.
interface cv32e40s_rf_scrub_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              clear_req_i;
    logic              busy_o;
    logic              clear_done_o;
    logic              pipe_we_i;
    logic [ADDR_W-1:0] pipe_waddr_i;
    logic [DATA_W-1:0] pipe_wdata_i;
    logic              pipe_rd_active_i;
    logic              rf_we_o;
    logic [ADDR_W-1:0] rf_waddr_o;
    logic [DATA_W-1:0] rf_wdata_o;
    logic              scrub_re_o;
    logic [ADDR_W-1:0] scrub_raddr_o;
    logic              scrub_ecc_err_i;
    logic              scrub_err_o;
    logic [ADDR_W-1:0] scrub_err_addr_o;
    logic [7:0]        scrub_err_cnt_o;

    modport slave (
        input  clear_req_i, pipe_we_i, pipe_waddr_i, pipe_wdata_i,
               pipe_rd_active_i, scrub_ecc_err_i,
        output busy_o, clear_done_o, rf_we_o, rf_waddr_o, rf_wdata_o,
               scrub_re_o, scrub_raddr_o, scrub_err_o, scrub_err_addr_o,
               scrub_err_cnt_o
    );

    modport master (
        output clear_req_i, pipe_we_i, pipe_waddr_i, pipe_wdata_i,
               pipe_rd_active_i, scrub_ecc_err_i,
        input  busy_o, clear_done_o, rf_we_o, rf_waddr_o, rf_wdata_o,
               scrub_re_o, scrub_raddr_o, scrub_err_o, scrub_err_addr_o,
               scrub_err_cnt_o
    );
endinterface

// File: rtl/cv32e40s_rf_scrub_ctrl.sv
// Register file clear sequencer and background ECC scrubber.
// CLEAR zeroes x1..x(NUM_REGS-1) while holding the pipeline off; IDLE passes
// pipeline writes through and steals idle read-port cycles for scrub reads.
module cv32e40s_rf_scrub_ctrl #(
    parameter int NUM_REGS       = 32,
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter int SCRUB_INTERVAL = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    cv32e40s_rf_scrub_ctrl_if.slave bus
);
    localparam int              CNT_W    = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SCRUB_INTERVAL - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LST = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_sptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W-1:0] r_err_addr;
    logic [7:0]        r_err_cnt;

    logic              w_busy;
    logic              w_fire;

    assign w_busy = (r_state == S_CLEAR);
    // The pipeline always wins the shared read port; a scrub only uses idle cycles.
    assign w_fire = (r_state == S_IDLE) && (r_cnt == CNT_MAX) && !bus.pipe_rd_active_i;

    // Write-port mux: clear sequencer owns the port in CLEAR, pipeline otherwise.
    // The clear write is masked while rst is held so the port is quiet in reset.
    always_comb begin
        if (w_busy) begin
            bus.rf_we_o    = !rst;
            bus.rf_waddr_o = r_ptr;
            bus.rf_wdata_o = {DATA_W{1'b0}};
        end else begin
            bus.rf_we_o    = bus.pipe_we_i;
            bus.rf_waddr_o = bus.pipe_waddr_i;
            bus.rf_wdata_o = bus.pipe_wdata_i;
        end
    end

    // Sequencer FSM, scrub interval/pointer and error reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_CLEAR;
            r_ptr      <= ADDR_ONE;
            r_sptr     <= ADDR_ONE;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_fire && bus.scrub_ecc_err_i;

            // A scrub issued alongside a clear request still reports and advances.
            if (w_fire && bus.scrub_ecc_err_i) begin
                r_err_addr <= r_sptr;
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
            if (w_fire) begin
                r_sptr <= (r_sptr == ADDR_LST) ? ADDR_ONE : r_sptr + ADDR_W'(1);
            end

            case (r_state)
                S_CLEAR: begin
                    r_cnt <= '0;
                    if (r_ptr == ADDR_LST) begin
                        r_state <= S_IDLE;
                        r_ptr   <= ADDR_ONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + ADDR_W'(1);
                    end
                end
                S_IDLE: begin
                    if (bus.clear_req_i) begin
                        r_state <= S_CLEAR;
                        r_ptr   <= ADDR_ONE;
                        r_cnt   <= '0;
                    end else if (w_fire) begin
                        r_cnt <= '0;
                    end else if (!bus.pipe_rd_active_i && (r_cnt != CNT_MAX)) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    assign bus.busy_o           = w_busy;
    assign bus.clear_done_o     = r_done;
    assign bus.scrub_re_o       = w_fire;
    assign bus.scrub_raddr_o    = r_sptr;
    assign bus.scrub_err_o      = r_err;
    assign bus.scrub_err_addr_o = r_err_addr;
    assign bus.scrub_err_cnt_o  = r_err_cnt;
endmodule
